// File: rtl/synth_pkg.sv
// Shared definitions for the note sequencer: pattern entry layout, FSM encoding
// and a decoder from a raw 12-bit entry word to its fields.
package synth_pkg;
  localparam int ENTRY_W  = 12;
  localparam int REST_BIT = 11;
  localparam int HP_MSB   = 10;
  localparam int HP_LSB   = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;
  localparam int HP_W     = HP_MSB - HP_LSB + 1;
  localparam int DUR_W    = DUR_MSB - DUR_LSB + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;

  typedef struct packed {
    logic             rest;
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] dur;
  } entry_t;

  function automatic entry_t decode_entry(input logic [ENTRY_W-1:0] w);
    entry_t e;
    e.rest = w[REST_BIT];
    e.hp   = w[HP_MSB:HP_LSB];
    e.dur  = w[DUR_MSB:DUR_LSB];
    return e;
  endfunction
endpackage

// File: rtl/tempo_prescaler.sv
// Tempo tick generator: counts 0..tdiv while enabled and flags the wrap cycle.
module tempo_prescaler #(
  parameter int TEMPO_W = 16
) (
  input  logic               synth_clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [TEMPO_W-1:0] tdiv,
  output logic               tick
);
  logic [TEMPO_W-1:0] cnt;

  assign tick = en && (cnt == tdiv);

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= tick ? '0 : cnt + TEMPO_W'(1);
  end
endmodule

// File: rtl/note_sequencer.sv
// Pattern sequencer feeding hp/active to the square-wave synth; plays steps
// 0..len with a one-cycle active=0 gap between notes to restart synth phase.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TEMPO_W = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               synth_clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [AW-1:0]      len,
  input  logic [TEMPO_W-1:0] tempo_div,
  output logic [HP_W-1:0]    hp,
  output logic               active,
  output logic [AW-1:0]      step,
  output logic               busy,
  output logic               done
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  state_t             state, state_nx;
  entry_t             rd;
  logic [TEMPO_W-1:0] tdiv_q;
  logic [DUR_W-1:0]   dur_ctr;
  logic               tick, note_end, last;

  always_ff @(posedge synth_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd = decode_entry(mem[step]);

  tempo_prescaler #(.TEMPO_W(TEMPO_W)) u_presc (
    .synth_clk (synth_clk),
    .rst_n     (rst_n),
    .clr       (state == S_FETCH),
    .en        (state == S_PLAY),
    .tdiv      (tdiv_q),
    .tick      (tick)
  );

  // step > len (len lowered mid-play) finishes the run just like step == len
  assign last     = (step >= len);
  assign note_end = (state == S_PLAY) && tick && (dur_ctr == '0);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: state_nx = S_PLAY;
      S_PLAY:  if (note_end) state_nx = (!last || loop) ? S_FETCH : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (stop) state_nx = S_IDLE;
  end

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      hp      <= '0;
      active  <= 1'b0;
      step    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tdiv_q  <= '0;
      dur_ctr <= '0;
    end else begin
      busy <= (state_nx != S_IDLE);
      done <= note_end && last && !loop && !stop;
      if (stop) begin
        active <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            step   <= '0;
            tdiv_q <= tempo_div;
          end
          // hp == 0 would never toggle the synth, so it is treated as a rest
          S_FETCH: begin
            hp      <= rd.hp;
            active  <= !rd.rest && (rd.hp != '0);
            dur_ctr <= rd.dur;
          end
          S_PLAY: if (tick) begin
            if (dur_ctr == '0) begin
              active <= 1'b0;
              if (!last)     step <= step + AW'(1);
              else if (loop) step <= '0;
            end else begin
              dur_ctr <= dur_ctr - DUR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: segment tables of expected per-cycle
// outputs plus hand sequences for start/stop collision and async reset.
module tb_note_sequencer;
  logic        synth_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [3:0]  wr_addr = '0, len = '0;
  logic [11:0] wr_data = '0;
  logic [15:0] tempo_div = '0;
  logic [6:0]  hp;
  logic        active, busy, done;
  logic [3:0]  step;
  int          errors = 0, checks = 0;

  // expected vector packs {active, step, busy, done, hp}
  typedef struct {
    int          n;
    logic        st, sp, wr;
    logic [3:0]  wa;
    logic [11:0] wd;
    logic [13:0] exp;
  } vec_t;
  vec_t tbl[$];

  note_sequencer dut (
    .synth_clk (synth_clk), .rst_n (rst_n),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .start (start), .stop (stop), .loop (loop), .len (len),
    .tempo_div (tempo_div),
    .hp (hp), .active (active), .step (step), .busy (busy), .done (done)
  );

  always #5 synth_clk = ~synth_clk;

  function automatic logic [13:0] o(logic a, logic [3:0] s, logic b, logic d, logic [6:0] h);
    return {a, s, b, d, h};
  endfunction

  function automatic void add(int n, logic [13:0] e, logic st = 1'b0, logic sp = 1'b0,
                              logic w = 1'b0, logic [3:0] wa = 4'd0, logic [11:0] wd = 12'd0);
    vec_t v;
    v.n = n; v.st = st; v.sp = sp; v.wr = w; v.wa = wa; v.wd = wd; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [13:0] exp);
    logic [13:0] got;
    got = {active, step, busy, done, hp};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (act,step,busy,done,hp)", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge synth_clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run(input int a, input int b, input string nm);
    for (int i = a; i < b; i++) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        if (c == 0) begin
          start = tbl[i].st;
          stop  = tbl[i].sp;
          if (tbl[i].wr) begin
            wr_en = 1'b1; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
          end
        end
        chk($sformatf("%s seg%0d cyc%0d", nm, i, c), tbl[i].exp);
        cyc();
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      end
    end
  endtask

  initial begin
    int p1, p2, p3, p4;
    // one-shot playback; a start during PLAY0 must be ignored
    p1 = tbl.size();
    add(1, o(0, 0, 1, 0, 0));
    add(8, o(1, 0, 1, 0, 10), 1'b1);
    add(1, o(0, 1, 1, 0, 10));
    add(4, o(1, 1, 1, 0, 20));
    add(1, o(0, 2, 1, 0, 20));
    add(4, o(0, 2, 1, 0, 5));
    add(1, o(0, 2, 0, 1, 5));
    add(2, o(0, 2, 0, 0, 5));
    // looping, live rewrite of entry 1, then stop mid-note
    p2 = tbl.size();
    add(1, o(0, 0, 1, 0, 5));
    add(8, o(1, 0, 1, 0, 10));
    add(1, o(0, 1, 1, 0, 10));
    add(4, o(1, 1, 1, 0, 20));
    add(1, o(0, 2, 1, 0, 20));
    add(4, o(0, 2, 1, 0, 5));
    add(1, o(0, 0, 1, 0, 5));
    add(8, o(1, 0, 1, 0, 10));
    add(1, o(0, 1, 1, 0, 10));
    add(4, o(1, 1, 1, 0, 20), 1'b0, 1'b0, 1'b1, 4'd1, 12'h1E0);
    add(1, o(0, 2, 1, 0, 20));
    add(4, o(0, 2, 1, 0, 5));
    add(1, o(0, 0, 1, 0, 5));
    add(8, o(1, 0, 1, 0, 10));
    add(1, o(0, 1, 1, 0, 10));
    add(2, o(1, 1, 1, 0, 30));
    add(1, o(1, 1, 1, 0, 30), 1'b0, 1'b1);
    add(3, o(0, 1, 0, 0, 30));
    // hp=0 non-rest entry, tempo 0: silent 2-cycle note then done
    p3 = tbl.size();
    add(1, o(0, 0, 1, 0, 30));
    add(2, o(0, 0, 1, 0, 0));
    add(1, o(0, 0, 0, 1, 0));
    add(1, o(0, 0, 0, 0, 0));
    p4 = tbl.size();

    #2 rst_n = 1'b0;
    #1 chk("reset_state", o(0, 0, 0, 0, 0));
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_after_reset", o(0, 0, 0, 0, 0));

    wr(4'd0, 12'h0A1);
    wr(4'd1, 12'h140);
    wr(4'd2, 12'h850);
    len = 4'd2; tempo_div = 16'd3; loop = 1'b0;
    kick();
    run(p1, p2, "oneshot");

    loop = 1'b1;
    kick();
    run(p2, p3, "loop");

    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", o(0, 1, 0, 0, 30));
    cyc();
    chk("start_stop_idle2", o(0, 1, 0, 0, 30));

    wr(4'd0, 12'h001);
    len = 4'd0; tempo_div = 16'd0; loop = 1'b0;
    kick();
    tempo_div = 16'd5;   // must not affect the run already started
    run(p3, p4, "hp0");

    wr(4'd0, 12'h0A1);
    len = 4'd2; tempo_div = 16'd3;
    kick();
    cyc(); cyc(); cyc();
    chk("pre_reset_play", o(1, 0, 1, 0, 10));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_midplay", o(0, 0, 0, 0, 0));
    cyc();
    rst_n = 1'b1;
    wr(4'd0, 12'h0A1);
    chk("idle_after_rereset", o(0, 0, 0, 0, 0));
    kick();
    chk("restart_fetch0", o(0, 0, 1, 0, 0));
    cyc();
    chk("restart_play0", o(1, 0, 1, 0, 10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Pattern sequencer that drives the `hp`/`active` inputs of the square-wave frequency synthesiser. It holds a writable 16-step note pattern and, on `start`, plays steps 0..`len` in order. Each step plays for a programmable number of tempo ticks, then deasserts `active` for one cycle to restart the synth's phase, optionally looping. It sits between the host register interface and the frequency synth, on the synth clock domain.

## Interface
- `DEPTH`, 16, pattern entries (index width = log2 DEPTH = 4)
- `TEMPO_W`, 16, width of tempo divider
- `synth_clk`  in  1  clock, all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  pattern write strobe, one entry per cycle
- `wr_addr`  in  4  pattern entry index
- `wr_data`  in  12  entry: [11] rest, [10:4] half-period hp, [3:0] dur (note lasts dur+1 ticks)
- `start`  in  1  begin playback at step 0 (ignored while busy)
- `stop`  in  1  abort playback; priority over start
- `loop`  in  1  after step `len`, wrap to step 0 instead of finishing
- `len`  in  4  index of last step played
- `tempo_div`  in  TEMPO_W  tick period = tempo_div+1 cycles
- `hp`  out  7  half-period to freq synth
- `active`  out  1  enable to freq synth
- `step`  out  4  index of current/last step
- `busy`  out  1  high in FETCH or PLAY
- `done`  out  1  one-cycle pulse on natural completion

## Operation
- States: IDLE, FETCH, PLAY. Reset: IDLE, `hp`=0, `active`=0, `step`=0, `busy`=0, `done`=0, prescaler=0, pattern contents undefined.
- IDLE: `start`=1 and `stop`=0 -> FETCH, `step`<=0, latch `tempo_div` into `tdiv_q`.
- FETCH (one cycle): read entry[`step`] combinationally, latch hp/rest/dur, prescaler<=0, dur_ctr<=dur, `active`<=0 -> PLAY.
- PLAY: `active`=1 unless rest=1 or latched hp==0 (both are rests; hp=0 never toggles the synth). Prescaler counts 0..`tdiv_q`; at `tdiv_q` it wraps and emits a tick. On a tick with dur_ctr==0 the note ends; otherwise dur_ctr decrements.
- Note end: if `step`!=`len` -> `step`+1, FETCH. If `step`==`len` and `loop`=1 -> `step`<=0, FETCH. Otherwise -> IDLE, `done` pulses, `active`<=0, `hp` holds its last value.
- If `step` > `len` (`len` lowered mid-play), the run ends at the next note end as if `step`==`len`.
- `len` and `loop` are sampled live at each note end. `tempo_div` is latched only at start.
- `stop` in any state -> IDLE next cycle, `active`<=0, no `done`. `stop` and `start` together -> stop wins.
- Writes are accepted in any state. Writing the playing entry does not affect the current note; it takes effect at that entry's next FETCH.
- `start` while busy is ignored (no restart).

## Timing
- All outputs are registered. `start` at edge N -> `busy`=1 after N, FETCH during N+1, `active`=1 after N+1.
- Each step occupies 1 + (dur+1)*(`tdiv_q`+1) cycles: 1 FETCH cycle with `active`=0, then PLAY.
- The 1-cycle `active`=0 gap between steps resets freq_synth phase, so every note starts at audio=0.
- `done` is asserted in the first IDLE cycle and lasts exactly one cycle.
- `tempo_div`=0 gives a tick every cycle, so the minimum step is 2 cycles (dur=0).
- Asynchronous reset mid-play forces all reset values immediately.

## Structure
- `synth_pkg`: entry field positions and widths (REST_BIT, HP_MSB/LSB, DUR_MSB/LSB), state encoding enum, HP_W=7.
- Sub-module `tempo_prescaler`: TEMPO_W counter with clear, compare to `tdiv_q`, tick output.
- Pattern memory: DEPTH x 12 reg array inside `note_sequencer`, one write port, one async read port.

## Test plan
- Write entries 0..2 = {0,hp 10,dur 1},{0,hp 20,dur 0},{1,hp 5,dur 0}, `len`=2, `tempo_div`=3, `loop`=0, start -> PLAY lengths 8/4/4 cycles; `active` high on steps 0-1 and low on step 2; `done` pulses 19 cycles after FETCH0.
- Same pattern with `loop`=1 -> `step` sequence 0,1,2,0,1…; no `done`; `active`=0 exactly 1 cycle at each boundary.
- `stop` asserted mid-note of step 1 -> `active`=0, `busy`=0 next cycle; no `done`; `step` holds 1.
- Rewrite entry 1 to hp 30 while it is playing -> current note keeps hp 20; next loop plays hp 30.
- Entry with hp=0, rest=0 -> `active` stays 0 for that step's full duration; `start`+`stop` together in IDLE -> remains IDLE.
- Assert `rst_n` low mid-PLAY -> `active`, `hp`, `busy`, `step` go to 0 asynchronously; after release, `start` replays from step 0.
